// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Target side of the RISC-V core's load/store port. One request is accepted
// at a time over a valid/ready handshake. WAIT_CYCLES wait states follow, then
// the access is performed and the response is held until the core accepts it.
//
// Address map (byte addresses):
//   0x00-0xEF  word RAM (word index addr[7:2], RAM_WORDS deep, byte lanes)
//   0xF0       LED register, R/W, only lane 0 is writable
//   0xF4       free-running 32-bit cycle counter, read-only
//   0xF8       sticky halt flag, a store of 1 in bit 0 sets it
//   0xFC       unmapped
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid / req_ready         request handshake (ready only when idle)
//   req_we, req_addr, req_wdata,  request fields, registered at accept
//   req_be
//   rsp_valid / rsp_ready         response handshake
//   rsp_rdata, rsp_err            load data (0 for stores/errors), error flag
//   led_out, halt_out             LED register and sticky halt request
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RAM_WORDS   = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  led_out,
  output logic        halt_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [7:0] ADDR_LED  = 8'hF0;
  localparam logic [7:0] ADDR_CYC  = 8'hF4;
  localparam logic [7:0] ADDR_HALT = 8'hF8;
  localparam logic [7:0] ADDR_NONE = 8'hFC;
  localparam logic [7:0] MMIO_BASE = 8'hF0;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg;
  logic        we_reg;
  logic [7:0]  addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] cycle_cnt_reg;
  logic [7:0]  led_reg;
  logic        halt_reg;
  logic        err_reg;
  logic [31:0] mmio_rdata_reg;
  logic        ram_sel_reg;

  logic        accept;
  logic        access;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/handshake decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // access marks the edge that enters RESP: the memory operation happens there.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    access     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (NO_WAIT) begin
            state_next = S_RESP;
            access     = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = S_RESP;
          access     = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Access operands. Without wait states the access coincides with the accept
  // edge, so the live request fields are used; otherwise the registered copy.
  // ---------------------------------------------------------------------------
  logic        acc_we;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;

  assign acc_we    = NO_WAIT ? req_we    : we_reg;
  assign acc_addr  = NO_WAIT ? req_addr  : addr_reg;
  assign acc_wdata = NO_WAIT ? req_wdata : wdata_reg;
  assign acc_be    = NO_WAIT ? req_be    : be_reg;

  logic [5:0] word_idx;
  logic       in_ram;
  logic       ram_oob;
  logic       acc_err;
  logic       acc_ok;
  logic       ram_wr;
  logic       ram_rd;
  logic       mmio_wr;

  assign word_idx = acc_addr[7:2];
  assign in_ram   = (acc_addr < MMIO_BASE);
  assign ram_oob  = in_ram && ({26'd0, word_idx} >= RAM_WORDS);
  assign acc_err  = (acc_addr[1:0] != 2'b00) || ram_oob ||
                    (acc_addr == ADDR_NONE) || (acc_we && (acc_addr == ADDR_CYC));
  assign acc_ok   = access && !acc_err;
  assign ram_wr   = acc_ok &&  acc_we && in_ram;
  assign ram_rd   = acc_ok && !acc_we && in_ram;
  assign mmio_wr  = acc_ok &&  acc_we && acc_be[0];

  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = 32'd0;
    case (acc_addr)
      ADDR_LED:  mmio_rdata = {24'd0, led_reg};
      ADDR_CYC:  mmio_rdata = cycle_cnt_reg;
      ADDR_HALT: mmio_rdata = {31'd0, halt_reg};
      default:   mmio_rdata = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, wait counter, MMIO registers and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg   <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= 8'd0;
      wdata_reg      <= 32'd0;
      be_reg         <= 4'd0;
      cycle_cnt_reg  <= 32'd0;
      led_reg        <= 8'd0;
      halt_reg       <= 1'b0;
      err_reg        <= 1'b0;
      mmio_rdata_reg <= 32'd0;
      ram_sel_reg    <= 1'b0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;

      if (accept) begin
        we_reg       <= req_we;
        addr_reg     <= req_addr;
        wdata_reg    <= req_wdata;
        be_reg       <= req_be;
        wait_cnt_reg <= WAIT_LOAD;
      end else if ((state_reg == S_WAIT) && (wait_cnt_reg != 4'd0)) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end

      if (access) begin
        err_reg        <= acc_err;
        ram_sel_reg    <= ram_rd;
        // Counter read returns the value present on this edge (pre-increment).
        mmio_rdata_reg <= (acc_ok && !acc_we && !in_ram) ? mmio_rdata : 32'd0;
        if (mmio_wr && (acc_addr == ADDR_LED)) begin
          led_reg <= acc_wdata[7:0];
        end
        if (mmio_wr && (acc_addr == ADDR_HALT) && acc_wdata[0]) begin
          halt_reg <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Word RAM split into four byte-wide lanes so each lane maps onto its own
  // block RAM with a registered read port. Contents are not reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (ram_wr && acc_be[gi]) begin
          mem[word_idx] <= acc_wdata[8*gi +: 8];
        end
        if (ram_rd) begin
          q_reg <= mem[word_idx];
        end
      end

      assign ram_q[8*gi +: 8] = q_reg;
    end
  endgenerate

  // The RAM read register only loads on a RAM read access, so this mux stays
  // stable for the whole RESP state; ram_sel_reg resets to 0 so rdata is 0.
  assign rsp_rdata = ram_sel_reg ? ram_q : mmio_rdata_reg;
  assign rsp_err   = err_reg;
  assign led_out   = led_reg;
  assign halt_out  = halt_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Three instances:
//   dut1: WAIT_CYCLES=1, RAM_WORDS=48 (main RAM/MMIO/error/backpressure cases,
//         RAM_WORDS=48 puts the out-of-range boundary at byte 0xC0)
//   dut0: WAIT_CYCLES=0 (back-to-back throughput)
//   dut3: WAIT_CYCLES=3 (reset in the middle of a wait)
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side cycle model: counts rising edges while out of reset.
  int unsigned tb_cyc = 0;
  int unsigned last_cap = 0;

  // ---------------- dut1 ----------------
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  led_out;
  logic        halt_out;

  dmem_responder #(.WAIT_CYCLES(1), .RAM_WORDS(48)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .led_out(led_out), .halt_out(halt_out)
  );

  // ---------------- dut0 ----------------
  logic        req_valid0, req_ready0, req_we0;
  logic [7:0]  req_addr0;
  logic [31:0] req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [7:0]  led_out0;
  logic        halt_out0;

  dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .led_out(led_out0), .halt_out(halt_out0)
  );

  // ---------------- dut3 ----------------
  logic        rst3_n;
  logic        req_valid3, req_ready3, req_we3;
  logic [7:0]  req_addr3;
  logic [31:0] req_wdata3;
  logic [3:0]  req_be3;
  logic        rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic [7:0]  led_out3;
  logic        halt_out3;

  dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .req_be(req_be3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .led_out(led_out3), .halt_out(halt_out3)
  );

  always @(posedge clk) begin
    if (rst_n) tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One dut1 transaction. Expected latency is WAIT_CYCLES+1 = 2. When use_cyc
  // is set the expected load data comes from the bench cycle model.
  task automatic xact(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold,
                      input logic [31:0] exp_rdata, input logic exp_err, input bit use_cyc,
                      output logic [31:0] got);
    int n;
    logic [31:0] exp_d;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(negedge clk);
    // Scramble the request fields: the DUT must use its registered copy.
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata; req_be = ~be;
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    check("latency", n, 32'd2);
    last_cap = tb_cyc;
    exp_d = use_cyc ? (tb_cyc - 1) : exp_rdata;
    got = rsp_rdata;
    check("rdata", rsp_rdata, exp_d);
    check("err", {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    $display("dut1 we=%0d addr=0x%02h wdata=0x%08h be=0x%h rdata=0x%08h err=%0d lat=%0d",
             we, addr, wdata, be, got, exp_err, n);
  endtask

  // One dut3 transaction; expected latency WAIT_CYCLES+1 = 4.
  task automatic xact3(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata);
    int n;
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = we; req_addr3 = addr; req_wdata3 = wdata; req_be3 = be;
    @(negedge clk);
    req_valid3 = 1'b0;
    n = 1;
    while (!rsp_valid3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("w3_latency", n, 32'd4);
    check("w3_rdata", rsp_rdata3, exp_rdata);
    check("w3_err", {31'd0, rsp_err3}, 32'd0);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    $display("dut3 we=%0d addr=0x%02h wdata=0x%08h rdata=0x%08h lat=%0d",
             we, addr, wdata, rsp_rdata3, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, r1, r2;
    int unsigned c1, c2;
    int hs;

    rst_n = 1'b0; rst3_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 0;
    req_valid3 = 0; req_we3 = 0; req_addr3 = 0; req_wdata3 = 0; req_be3 = 0; rsp_ready3 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_led",       {24'd0, led_out}, 32'd0);
    check("rst_halt",      {31'd0, halt_out}, 32'd0);

    // RAM store/load
    xact(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0, r);
    xact(1'b0, 8'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 1'b0, r);

    // Byte lanes
    xact(1'b1, 8'h20, 32'h11223344, 4'hF,    0, 32'h0, 1'b0, 1'b0, r);
    xact(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0, 1'b0, 1'b0, r);
    xact(1'b0, 8'h20, 32'h0,        4'h0,    0, 32'h11BB33DD, 1'b0, 1'b0, r);

    // be=0 store is a legal no-op
    xact(1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0, 1'b0, r);
    xact(1'b0, 8'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 1'b0, r);

    // LED register
    xact(1'b1, 8'hF0, 32'h000000A5, 4'h1, 0, 32'h0, 1'b0, 1'b0, r);
    check("led_after_store", {24'd0, led_out}, 32'h000000A5);
    xact(1'b0, 8'hF0, 32'h0, 4'hF, 0, 32'h000000A5, 1'b0, 1'b0, r);
    xact(1'b1, 8'hF0, 32'h0000005A, 4'hE, 0, 32'h0, 1'b0, 1'b0, r);
    check("led_be0_only", {24'd0, led_out}, 32'h000000A5);

    // Halt flag
    xact(1'b1, 8'hF8, 32'h1, 4'h1, 0, 32'h0, 1'b0, 1'b0, r);
    check("halt_set", {31'd0, halt_out}, 32'd1);
    xact(1'b1, 8'hF8, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0, r);
    check("halt_sticky", {31'd0, halt_out}, 32'd1);
    xact(1'b0, 8'hF8, 32'h0, 4'hF, 0, 32'h1, 1'b0, 1'b0, r);

    // Cycle counter: two reads, delta equals elapsed edges
    xact(1'b0, 8'hF4, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b1, r1);
    c1 = last_cap;
    repeat (7) @(negedge clk);
    xact(1'b0, 8'hF4, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b1, r2);
    c2 = last_cap;
    check("cyc_delta", r2 - r1, c2 - c1);

    // Errors
    xact(1'b0, 8'h13, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b1, 8'h11, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b0, 8'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1'b0, 1'b0, r);
    xact(1'b1, 8'hF4, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b0, 8'hF4, 32'h0,        4'hF, 0, 32'h0, 1'b0, 1'b1, r);
    xact(1'b0, 8'hFC, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b1, 8'hF2, 32'h000000FF, 4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b0, 8'hF0, 32'h0,        4'hF, 0, 32'h000000A5, 1'b0, 1'b0, r);

    // RAM_WORDS boundary (48 words: 0xBC last valid, 0xC0 out of range)
    xact(1'b1, 8'hBC, 32'h600DCAFE, 4'hF, 0, 32'h0, 1'b0, 1'b0, r);
    xact(1'b1, 8'hC0, 32'h00000BAD, 4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b0, 8'hC0, 32'h0,        4'hF, 0, 32'h0, 1'b1, 1'b0, r);
    xact(1'b0, 8'hBC, 32'h0,        4'hF, 0, 32'h600DCAFE, 1'b0, 1'b0, r);

    // Backpressure: response held for 5 cycles
    xact(1'b0, 8'h10, 32'h0, 4'hF, 5, 32'hDEADBEEF, 1'b0, 1'b0, r);

    // WAIT_CYCLES=0: one store then four loads, request and rsp_ready held high
    @(negedge clk);
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 8'hF0; req_wdata0 = 32'h77; req_be0 = 4'h1;
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid0) begin
        hs++;
        check("w0_err", {31'd0, rsp_err0}, 32'd0);
        check("w0_rdata", rsp_rdata0, (hs == 1) ? 32'h0 : 32'h77);
        $display("dut0 txn=%0d rdata=0x%08h err=%0d", hs, rsp_rdata0, rsp_err0);
        req_we0 = 1'b0; req_wdata0 = 32'h0;
      end
    end
    req_valid0 = 1'b0;
    rsp_ready0 = 1'b0;
    check("w0_handshakes_10cyc", hs, 32'd5);
    check("w0_led", {24'd0, led_out0}, 32'h77);

    // WAIT_CYCLES=3: reset during the second wait cycle of a store
    xact3(1'b1, 8'h04, 32'hCAFEF00D, 4'hF, 32'h0);
    xact3(1'b1, 8'hF0, 32'h0000003C, 4'h1, 32'h0);
    check("w3_led_set", {24'd0, led_out3}, 32'h3C);
    xact3(1'b0, 8'h04, 32'h0, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 8'h04; req_wdata3 = 32'h12345678; req_be3 = 4'hF;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    check("w3_rst_req_ready", {31'd0, req_ready3}, 32'd1);
    check("w3_rst_rsp_valid", {31'd0, rsp_valid3}, 32'd0);
    check("w3_rst_rdata", rsp_rdata3, 32'd0);
    check("w3_rst_err", {31'd0, rsp_err3}, 32'd0);
    check("w3_rst_led", {24'd0, led_out3}, 32'd0);
    check("w3_rst_halt", {31'd0, halt_out3}, 32'd0);
    repeat (2) @(negedge clk);
    rst3_n = 1'b1;
    #1;
    check("w3_release_req_ready", {31'd0, req_ready3}, 32'd1);
    repeat (4) @(negedge clk);
    check("w3_no_late_rsp", {31'd0, rsp_valid3}, 32'd0);
    xact3(1'b0, 8'h04, 32'h0, 4'hF, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
